// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// One operation is in flight at a time: IDLE (accept) -> EXEC (compute) -> RESP (hand back).
module alu_arbiter #(
    parameter int unsigned FIRST_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic [3:0]  req0_op,
    input  logic [4:0]  req0_shamt,
    input  logic [15:0] req0_imm,
    input  logic        req0_bne,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    input  logic [3:0]  req1_op,
    input  logic [4:0]  req1_shamt,
    input  logic [15:0] req1_imm,
    input  logic        req1_bne,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,

    output logic [31:0] rsp_result,
    output logic        rsp_zero,

    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_op,
    output logic [4:0]  alu_shamt,
    output logic [15:0] alu_imm,
    output logic        alu_bne,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // "Last granted" history is preset to the other requester so FIRST_PRIO wins first.
    localparam logic RESET_LAST = (FIRST_PRIO == 32'd0) ? 1'b1 : 1'b0;

    state_t      state_r;
    state_t      next_state_s;

    logic [31:0] in1_r;
    logic [31:0] in2_r;
    logic [3:0]  op_r;
    logic [4:0]  shamt_r;
    logic [15:0] imm_r;
    logic        bne_r;
    logic        grant_r;
    logic        last_grant_r;
    logic [31:0] result_r;
    logic        zero_r;

    logic        accept_s;
    logic        grant_s;
    logic        rsp_take_s;
    logic [31:0] sel_in1_s;
    logic [31:0] sel_in2_s;
    logic [3:0]  sel_op_s;
    logic [4:0]  sel_shamt_s;
    logic [15:0] sel_imm_s;
    logic        sel_bne_s;

    // Round-robin arbitration; only meaningful in IDLE and out of reset.
    always_comb begin
        accept_s = 1'b0;
        grant_s  = 1'b0;
        if (rst_n && (state_r == ST_IDLE)) begin
            if (req0_valid && req1_valid) begin
                accept_s = 1'b1;
                grant_s  = ~last_grant_r;
            end else if (req0_valid) begin
                accept_s = 1'b1;
                grant_s  = 1'b0;
            end else if (req1_valid) begin
                accept_s = 1'b1;
                grant_s  = 1'b1;
            end else begin
                accept_s = 1'b0;
                grant_s  = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
            grant_s  = 1'b0;
        end
    end

    // Operand mux feeding the operand registers from the winning requester.
    always_comb begin
        sel_in1_s   = req0_in1;
        sel_in2_s   = req0_in2;
        sel_op_s    = req0_op;
        sel_shamt_s = req0_shamt;
        sel_imm_s   = req0_imm;
        sel_bne_s   = req0_bne;
        if (grant_s) begin
            sel_in1_s   = req1_in1;
            sel_in2_s   = req1_in2;
            sel_op_s    = req1_op;
            sel_shamt_s = req1_shamt;
            sel_imm_s   = req1_imm;
            sel_bne_s   = req1_bne;
        end else begin
            sel_in1_s   = req0_in1;
            sel_in2_s   = req0_in2;
            sel_op_s    = req0_op;
            sel_shamt_s = req0_shamt;
            sel_imm_s   = req0_imm;
            sel_bne_s   = req0_bne;
        end
    end

    // Response consumption is taken only from the requester that owns the result.
    always_comb begin
        rsp_take_s = 1'b0;
        if (grant_r) begin
            rsp_take_s = rsp1_ready;
        end else begin
            rsp_take_s = rsp0_ready;
        end
    end

    // Next-state logic for the IDLE/EXEC/RESP sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                next_state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_take_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture and grant bookkeeping; history moves only on real acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in1_r        <= 32'd0;
            in2_r        <= 32'd0;
            op_r         <= 4'd0;
            shamt_r      <= 5'd0;
            imm_r        <= 16'd0;
            bne_r        <= 1'b0;
            grant_r      <= 1'b0;
            last_grant_r <= RESET_LAST;
        end else if (accept_s) begin
            in1_r        <= sel_in1_s;
            in2_r        <= sel_in2_s;
            op_r         <= sel_op_s;
            shamt_r      <= sel_shamt_s;
            imm_r        <= sel_imm_s;
            bne_r        <= sel_bne_s;
            grant_r      <= grant_s;
            last_grant_r <= grant_s;
        end
    end

    // Result capture at the end of the single EXEC cycle; held through RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_r <= 32'd0;
            zero_r   <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            result_r <= alu_result;
            zero_r   <= alu_zero;
        end
    end

    assign req0_ready = accept_s & ~grant_s;
    assign req1_ready = accept_s &  grant_s;

    assign rsp0_valid = (state_r == ST_RESP) & ~grant_r;
    assign rsp1_valid = (state_r == ST_RESP) &  grant_r;

    assign rsp_result = result_r;
    assign rsp_zero   = zero_r;

    assign alu_in1   = in1_r;
    assign alu_in2   = in2_r;
    assign alu_op    = op_r;
    assign alu_shamt = shamt_r;
    assign alu_imm   = imm_r;
    assign alu_bne   = bne_r;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters SHALL be: FIRST_PRIO, default 0, index of the requester that wins the first contention after reset.
REQ-002 Ports SHALL be (N = 0, 1; one port per requester; name, direction, width, meaning):
  clk            input   1   single clock; all state updates on rising edge
  rst_n          input   1   reset, synchronous, active-low
  reqN_valid     input   1   requester N presents an operation
  reqN_ready     output  1   requester N's operation is accepted this cycle
  reqN_in1       input   32  operand 1
  reqN_in2       input   32  operand 2
  reqN_op        input   4   ALU operation code
  reqN_shamt     input   5   shift amount
  reqN_imm       input   16  immediate for lui/ori
  reqN_bne       input   1   Zero_flag polarity select
  rspN_valid     output  1   result for requester N is available
  rspN_ready     input   1   requester N consumes the result
  rsp_result     output  32  registered ALU result, shared by both requesters
  rsp_zero       output  1   registered ALU Zero_flag, shared
  alu_in1/alu_in2  output  32  to ALU In1/In2
  alu_op         output  4   to ALU OP
  alu_shamt      output  5   to ALU shamt
  alu_imm        output  16  to ALU immediate
  alu_bne        output  1   to ALU bne
  alu_result     input   32  from ALU result (combinational)
  alu_zero       input   1   from ALU Zero_flag (combinational)

Function
REQ-003 The block SHALL time-share one combinational ALU between two requesters, one operation in flight at a time.
REQ-004 States SHALL be IDLE, EXEC, RESP; encoding is free.
REQ-005 IDLE: if neither reqN_valid, stay in IDLE; otherwise grant one requester, assert its reqN_ready combinationally in that cycle, latch its in1/in2/op/shamt/imm/bne into operand registers, record the grant index, go to EXEC.
REQ-006 Only one reqN_ready SHALL be high per cycle; both SHALL be low outside IDLE and when the matching reqN_valid is low.
REQ-007 Arbitration SHALL be round-robin: with one valid requester, grant it; with both valid, grant the requester not granted last; the first grant after reset with both valid goes to FIRST_PRIO.
REQ-008 alu_* outputs SHALL be driven from the operand registers in every state, never directly from reqN_* inputs.
REQ-009 EXEC: lasts exactly one cycle; at its closing edge capture alu_result into rsp_result and alu_zero into rsp_zero; go to RESP.
REQ-010 RESP: assert rspN_valid for the granted index only; hold rsp_result/rsp_zero stable; on rspN_ready high, go to IDLE at the next edge.
REQ-011 Latency SHALL be fixed: acceptance edge -> rspN_valid high two cycles later; minimum issue interval is 3 cycles per operation.
REQ-012 rspN_ready while rspN_valid is low SHALL be ignored; reqN_valid changes outside IDLE SHALL be ignored.
REQ-013 A requester deasserting reqN_valid in the same cycle it would be granted SHALL NOT be granted; the round-robin pointer updates only on actual acceptance.
REQ-014 Operand/result widths SHALL pass through unmodified; no sign extension or truncation occurs in this block.

Reset
REQ-015 When rst_n is low at a rising edge: state <= IDLE, operand registers <= 0, rsp_result <= 0, rsp_zero <= 0, grant-history <= such that FIRST_PRIO wins next contention.
REQ-016 During and immediately after reset: reqN_ready = 0 while rst_n low, rspN_valid = 0, alu_* = 0.
REQ-017 Reset asserted in EXEC or RESP SHALL abort the operation; the pending result is discarded and no rspN_valid is produced for it.

Verification
REQ-018 Single add: req0 valid, op=0110, in1=5, in2=7 -> req0_ready high that cycle; two cycles later rsp0_valid=1, rsp_result=12, rsp_zero=0.
REQ-019 Contention: both valid continuously with FIRST_PRIO=0, rspN_ready tied high -> grants alternate 0,1,0,1; each grant 3 cycles apart.
REQ-020 Backpressure: req1 sub in1=9, in2=9, bne=0, rsp1_ready low for 5 cycles -> rsp1_valid held, rsp_result=0, rsp_zero=1 stable, no new grant until rsp1_ready.
REQ-021 Immediate path: req0 op=1110, imm=0x1234 -> rsp_result=0x12340000; then op=1111, in1=0x00FF0000, imm=0x00AB -> 0x00FF00AB.
REQ-022 Reset mid-operation: rst_n low during EXEC -> next cycle IDLE, rsp_result=0, no rspN_valid; next request served normally with FIRST_PRIO priority.
REQ-023 Input isolation: change req0_in1 after acceptance -> alu_in1 and final rsp_result reflect latched value only.
